// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared constants, the stereo frame type and the serializer
//                bit-select helper for the I2S transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int FIFO_DEPTH = 4;

  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_frame_t;

  // Serial bit for a given frame position. Each slot carries its sample
  // MSB-first starting one BCLK after the LRCLK transition; the unused tail
  // of each 32-bit slot is zero.
  function automatic logic slot_bit(stereo_frame_t f, logic [BIT_CNT_W-1:0] bit_cnt);
    logic [3:0] idx;
    slot_bit = 1'b0;
    idx      = 4'd0;
    if (bit_cnt >= 6'd1 && bit_cnt <= 6'd16) begin
      idx      = 4'(6'd16 - bit_cnt);
      slot_bit = f.left[idx];
    end else if (bit_cnt >= 6'd33 && bit_cnt <= 6'd48) begin
      idx      = 4'(6'd48 - bit_cnt);
      slot_bit = f.right[idx];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : FIFO_DEPTH-entry synchronous FIFO of stereo frames with
//                count-based full/empty flags and a fall-through read port.
//  Ports       : clk, reset (async, active-high)
//                push / wr_data  - write request and frame (ignored when full)
//                pop  / rd_data  - read request (ignored when empty) and head
//                full, empty     - decoded from the registered count
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
  import i2s_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  stereo_frame_t wr_data,
  input  logic          pop,
  output stereo_frame_t rd_data,
  output logic          full,
  output logic          empty
);

  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  stereo_frame_t         mem_q [FIFO_DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_transmitter
//  Description : Stereo 16-bit I2S transmitter. Frames are buffered in a
//                4-deep FIFO and serialized in 64-BCLK frames (32 per slot).
//  Ports       : clk, reset (async, active-high)
//                in_valid/in_ready/in_left/in_right - upstream frame handshake
//                BCLK, LRCLK, DIN                   - registered I2S outputs
//                underrun - one-clk pulse when a frame starts with FIFO empty
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                DIN,
  output logic                underrun
);

  localparam int                DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(BCLK_DIV / 2);

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 bclk_q, bclk_d;
  logic                 lrclk_q, lrclk_d;
  logic                 din_q, din_d;
  logic                 underrun_q, underrun_d;
  stereo_frame_t        frame_q, frame_d;

  logic                 bclk_fall;
  logic                 frame_wrap;
  logic                 fifo_full;
  logic                 fifo_empty;
  stereo_frame_t        fifo_head;
  stereo_frame_t        in_frame;

  assign in_frame   = '{left: in_left, right: in_right};
  assign in_ready   = !fifo_full;
  assign bclk_fall  = (div_cnt_q == DIV_LAST);
  assign frame_wrap = bclk_fall && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));

  // The pop decision looks only at the registered count, so a frame pushed
  // on the wrap clk cannot rescue an empty FIFO; it goes out one frame later.
  sample_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .wr_data (in_frame),
    .pop     (frame_wrap),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    div_cnt_d  = bclk_fall ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d  = bclk_fall ? bit_cnt_q + 1'b1 : bit_cnt_q;
    bclk_d     = (div_cnt_d >= DIV_HALF);

    frame_d    = frame_q;
    underrun_d = 1'b0;
    if (frame_wrap) begin
      frame_d    = fifo_empty ? '0 : fifo_head;
      underrun_d = fifo_empty;
    end

    // Word select and data only move with BCLK falling. The frame register
    // reloads on the wrap into bit 0, which always carries a zero, so the
    // new frame is in place before bit 1 is serialized.
    lrclk_d = lrclk_q;
    din_d   = din_q;
    if (bclk_fall) begin
      lrclk_d = bit_cnt_d[BIT_CNT_W-1];
      din_d   = slot_bit(frame_q, bit_cnt_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      din_q      <= 1'b0;
      underrun_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      din_q      <= din_d;
      underrun_q <= underrun_d;
      frame_q    <= frame_d;
    end
  end

  assign BCLK     = bclk_q;
  assign LRCLK    = lrclk_q;
  assign DIN      = din_q;
  assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_transmitter
//  Description : Directed self-checking bench for i2s_transmitter
//                (BCLK_DIV = 16, so one frame = 1024 clk).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_transmitter;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_left  = 16'h0;
  logic [15:0] in_right = 16'h0;
  logic        in_ready;
  logic        BCLK;
  logic        LRCLK;
  logic        DIN;
  logic        underrun;

  i2s_transmitter #(.BCLK_DIV(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_left  (in_left),
    .in_right (in_right),
    .BCLK     (BCLK),
    .LRCLK    (LRCLK),
    .DIN      (DIN),
    .underrun (underrun)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cycle position since reset release and a count-only FIFO model.
  int cyc         = 0;
  int frames_done = 0;
  int m_cnt       = 0;
  int bad_bclk    = 0;
  int bad_chg     = 0;
  int bad_uf      = 0;
  int bad_rdy     = 0;
  logic        prev_din = 1'b0;
  logic        prev_lr  = 1'b0;
  logic [63:0] acc_din  = 64'h0;
  logic [63:0] acc_lr   = 64'h0;
  logic        acc_uf   = 1'b0;
  logic [63:0] log_din [0:15];
  logic [63:0] log_lr  [0:15];
  logic        log_uf  [0:15];

  // Expected serialized frames, bit position p stored at [63-p].
  logic [63:0] exp_din [0:15] = '{
    64'h00000000_00000000,   // 0  reset frame register
    64'h52E18000_00008000,   // 1  A5C3 / 0001
    64'h00000000_00000000,   // 2  underrun
    64'h00000000_00000000,   // 3  underrun
    64'h00000000_00000000,   // 4  underrun, push on wrap clk
    64'h091A0000_7F6E0000,   // 5  1234 / FEDC
    64'h3FFF8000_40000000,   // 6  7FFF / 8000
    64'h07878000_78780000,   // 7  0F0F / F0F0
    64'h08888000_11110000,   // 8  1111 / 2222
    64'h19998000_22220000,   // 9  3333 / 4444
    64'h2AAA8000_33330000,   // 10 5555 / 6666
    64'h3BBB8000_44440000,   // 11 7777 / 8888
    64'h4CCC8000_55550000,   // 12 9999 / AAAA
    64'h66660000_77770000,   // 13 CCCC / EEEE
    64'h00000000_00000000,   // 14 first frame after mid-frame reset
    64'h00000000_00000000    // 15 FIFO contents were discarded
  };
  logic exp_uf [0:15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples the current (negedge) state, advances one clk, updates the model.
  task automatic tick(output logic accepted);
    int   div;
    int   bitn;
    logic push_now;
    logic pop_now;
    div  = cyc % 16;
    bitn = (cyc / 16) % 64;
    if (BCLK !== (div >= 8)) bad_bclk++;
    if (in_ready !== (m_cnt < 4)) bad_rdy++;
    if (div == 0 && bitn == 0) acc_uf = underrun;
    else if (underrun !== 1'b0) bad_uf++;
    if (div != 0 && (DIN !== prev_din || LRCLK !== prev_lr)) bad_chg++;
    prev_din = DIN;
    prev_lr  = LRCLK;
    if (div == 8) begin
      acc_din[63 - bitn] = DIN;
      acc_lr[63 - bitn]  = LRCLK;
    end
    if (div == 15 && bitn == 63) begin
      if (frames_done < 16) begin
        log_din[frames_done] = acc_din;
        log_lr[frames_done]  = acc_lr;
        log_uf[frames_done]  = acc_uf;
      end
      frames_done++;
    end
    push_now = in_valid && (m_cnt < 4);
    pop_now  = (div == 15 && bitn == 63) && (m_cnt > 0);
    @(posedge clk);
    if (pop_now)  m_cnt--;
    if (push_now) m_cnt++;
    cyc++;
    accepted = push_now;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    for (int k = 0; k < 3000; k++) begin
      tick(acc);
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("push_accept", 64'(acc), 64'd1);
  endtask

  task automatic tick_until(input int target);
    logic d;
    for (int k = 0; k < 2000; k++) begin
      if (cyc >= target) break;
      tick(d);
    end
  endtask

  task automatic wait_frames_to(input int target);
    logic d;
    for (int k = 0; k < 20000; k++) begin
      if (frames_done >= target) break;
      tick(d);
    end
    chk("frame_wait", 64'(frames_done >= target), 64'd1);
  endtask

  task automatic restart_model();
    cyc      = 0;
    m_cnt    = 0;
    prev_din = 1'b0;
    prev_lr  = 1'b0;
    acc_din  = 64'h0;
    acc_lr   = 64'h0;
    acc_uf   = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_bclk",     64'(BCLK),     64'd0);
    chk("rst_lrclk",    64'(LRCLK),    64'd0);
    chk("rst_din",      64'(DIN),      64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    restart_model();

    // Single frame, then idle frames with underrun
    push(16'hA5C3, 16'h0001);
    wait_frames_to(3);

    // Push exactly on the 63->0 wrap clk with the FIFO empty
    tick_until(4095);
    push(16'h1234, 16'hFEDC);
    wait_frames_to(5);

    // Simultaneous push and pop at count 1
    push(16'h7FFF, 16'h8000);
    tick_until(6143);
    push(16'h0F0F, 16'hF0F0);
    chk("push_pop_cycle", 64'(cyc), 64'd6144);
    wait_frames_to(7);

    // Five back-to-back pushes into an empty FIFO
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    push(16'h5555, 16'h6666);
    push(16'h7777, 16'h8888);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    push(16'h9999, 16'hAAAA);
    chk("fifth_after_pop", 64'(cyc), 64'd8193);
    chk("refull_in_ready", 64'(in_ready), 64'd0);
    // Held push while full across a pop
    push(16'hCCCC, 16'hEEEE);
    chk("sixth_after_pop", 64'(cyc), 64'd9217);
    chk("still_full", 64'(in_ready), 64'd0);
    wait_frames_to(14);

    // Mid-frame reset at bit_cnt 20 with three frames queued
    push(16'h5A5A, 16'hA5A5);
    push(16'h0102, 16'h0304);
    push(16'hFFFF, 16'hFFFF);
    tick_until(14336 + 20 * 16 + 10);
    chk("pre_reset_bclk", 64'(BCLK), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_bclk",     64'(BCLK),     64'd0);
    chk("mid_rst_lrclk",    64'(LRCLK),    64'd0);
    chk("mid_rst_din",      64'(DIN),      64'd0);
    chk("mid_rst_underrun", 64'(underrun), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    restart_model();
    wait_frames_to(16);

    // Per-frame results
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("frame%0d_din", i),   log_din[i],     exp_din[i]);
      chk($sformatf("frame%0d_uf", i),    64'(log_uf[i]), 64'(exp_uf[i]));
      chk($sformatf("frame%0d_lrclk", i), log_lr[i],      64'h00000000_FFFFFFFF);
    end

    // Cycle-level properties accumulated over the whole run
    chk("bclk_waveform",    64'(bad_bclk), 64'd0);
    chk("edge_alignment",   64'(bad_chg),  64'd0);
    chk("underrun_timing",  64'(bad_uf),   64'd0);
    chk("in_ready_vs_count", 64'(bad_rdy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
